// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Load/store access-type encodings shared by the decoder and
//               the LSU. Values follow the RV32 funct3 field of LOAD/STORE.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : LSU-wide types and constants: controller state encoding,
//               base byte-enable patterns and the access legality rule.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  import decoder_pkg::*;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_DONE   = 2'd2
  } lsu_state_t;

  // Byte-enable patterns for lane 0; shifted to the addressed lane.
  localparam logic [3:0] LSU_BE_B = 4'b0001;
  localparam logic [3:0] LSU_BE_H = 4'b0011;
  localparam logic [3:0] LSU_BE_W = 4'b1111;

  // Naturally aligned accesses only; unsigned variants exist for loads only.
  function automatic logic lsu_access_legal(input logic       we,
                                            input logic [2:0] size,
                                            input logic [1:0] off);
    logic ok;
    case (size)
      LDST_B:  ok = 1'b1;
      LDST_BU: ok = ~we;
      LDST_H:  ok = ~off[0];
      LDST_HU: ok = ~we & ~off[0];
      LDST_W:  ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_rdata_ext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_rdata_ext
// Description : Combinational load-data lane select and sign/zero extension.
// Ports       : rdata_i  - raw 32-bit word from memory
//               size_i   - access type (LDST_* encoding)
//               off_i    - byte offset within the word (addr[1:0])
//               data_o   - extended 32-bit load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_rdata_ext
  import decoder_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data_o = {24'd0, byte_sel};
      LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Single-outstanding load/store controller between the core
//               and a ready-handshake memory port, with bus timeout.
// Ports       : clk_i, rst_ni          - clock, async active-low reset
//               core_req/we/size/addr/wd_i - memory instruction from decoder
//               core_rd_o              - extended load data (held)
//               core_stall_o           - stall PC / regfile write
//               core_misalign_o        - pulse: illegal/misaligned access
//               core_fault_o           - pulse: bus timeout
//               mem_req/we/be/addr/wd_o - memory request
//               mem_rd_i, mem_ready_i  - memory response
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
  import decoder_pkg::*;
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;

  logic        stall_c, misalign_c, legal_c;
  logic [3:0]  be_new;
  logic [31:0] wd_new, ext_data;

  // Extension uses the registered request so core inputs may change freely.
  lsu_rdata_ext u_rdata_ext (
    .rdata_i (mem_rd_i),
    .size_i  (size_q),
    .off_i   (addr_q[1:0]),
    .data_o  (ext_data)
  );

  assign legal_c = lsu_access_legal(core_we_i, core_size_i, core_addr_i[1:0]);

  always_comb begin
    case (core_size_i)
      LDST_B, LDST_BU: begin
        be_new = LSU_BE_B << core_addr_i[1:0];
        wd_new = {4{core_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        be_new = LSU_BE_H << {core_addr_i[1], 1'b0};
        wd_new = {2{core_wd_i[15:0]}};
      end
      default: begin
        be_new = LSU_BE_W;
        wd_new = core_wd_i;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    stall_c    = 1'b0;
    misalign_c = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (core_req_i) begin
          if (legal_c) begin
            stall_c = 1'b1;
            we_d    = core_we_i;
            size_d  = core_size_i;
            be_d    = be_new;
            addr_d  = core_addr_i;
            wd_d    = wd_new;
            cnt_d   = 8'd0;
            fault_d = 1'b0;
            state_d = LSU_ACCESS;
          end else begin
            misalign_c = 1'b1;
          end
        end
      end
      LSU_ACCESS: begin
        stall_c = 1'b1;
        // Ready wins over a timeout landing in the same cycle.
        if (mem_ready_i) begin
          if (!we_q) rd_d = ext_data;
          state_d = LSU_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TMO_LIMIT) begin
            fault_d = 1'b1;
            if (!we_q) rd_d = 32'd0;
            state_d = LSU_DONE;
          end
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      be_q    <= 4'd0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Combinational core handshakes are masked so reset forces them low too.
  assign core_stall_o    = stall_c & rst_ni;
  assign core_misalign_o = misalign_c & rst_ni;
  assign core_fault_o    = (state_q == LSU_DONE) & fault_q;
  assign core_rd_o       = rd_q;
  assign mem_req_o       = (state_q == LSU_ACCESS);
  assign mem_we_o        = we_q;
  assign mem_be_o        = be_q;
  assign mem_addr_o      = addr_q;
  assign mem_wd_o        = wd_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl: directed vector table,
//               reset-in-flight sequence and randomized transactions against
//               a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_ctrl;

  import decoder_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [2:0]  core_size = 3'd0;
  logic [31:0] core_addr = 32'd0, core_wd = 32'd0;
  logic [31:0] core_rd;
  logic        core_stall, core_mis, core_fault;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd;
  logic [31:0] mem_rd = 32'd0;
  logic        mem_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_rd = 32'd0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(core_rd), .core_stall_o(core_stall),
    .core_misalign_o(core_mis), .core_fault_o(core_fault),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
    logic        fault;
    int          cyc;
  } vec_t;

  vec_t vecs[15];

  // Reference behaviour computed from the access rules with plain arithmetic.
  task automatic model(input vec_t v_in, input logic [31:0] prev_rd, output vec_t v);
    int n, off;
    logic sgn;
    logic [63:0] mask, lane;
    v = v_in;
    case (v.size)
      LDST_B, LDST_BU: n = 1;
      LDST_H, LDST_HU: n = 2;
      LDST_W:          n = 4;
      default:         n = 0;
    endcase
    sgn = (v.size == LDST_B) || (v.size == LDST_H);
    v.mis = (n == 0) || (v.addr % n != 0) ||
            (v.we && (v.size == LDST_BU || v.size == LDST_HU));
    v.be = 4'd0; v.mwd = 32'd0; v.rd = prev_rd; v.fault = 1'b0; v.cyc = 0;
    if (!v.mis) begin
      off  = int'(v.addr % 4);
      mask = (64'd1 << (8 * n)) - 64'd1;
      v.be = 4'(((1 << n) - 1) << off);
      for (int k = 0; k < 4; k++)
        v.mwd[8*k +: 8] = v.wd[8*(k % n) +: 8];
      lane = (64'(v.rdata) >> (8 * off)) & mask;
      if (sgn && lane[8*n-1]) lane = lane | ~mask;
      v.fault = (v.waits >= TMO);
      v.cyc   = v.fault ? TMO : v.waits + 1;
      if (!v.we) v.rd = v.fault ? 32'd0 : lane[31:0];
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int  cyc;
    bit  seen_done;
    @(negedge clk);
    core_req = 1'b1; core_we = v.we; core_size = v.size;
    core_addr = v.addr; core_wd = v.wd; mem_rd = v.rdata; mem_ready = 1'b0;
    #1;
    check({tag, " misalign"}, 32'(core_mis), 32'(v.mis));
    check({tag, " idle stall"}, 32'(core_stall), 32'(!v.mis));
    if (v.mis) begin
      @(posedge clk); #1;
      check({tag, " no mem_req"}, 32'(mem_req), 32'd0);
      check({tag, " rd hold"}, core_rd, v.rd);
      core_req = 1'b0;
      return;
    end
    cyc = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < 20) begin
      @(negedge clk);
      mem_ready = 1'b0;
      // Core inputs outside IDLE are junk and must be ignored.
      core_req = 1'($urandom); core_we = 1'($urandom);
      core_size = 3'($urandom); core_addr = $urandom; core_wd = $urandom;
      #1;
      if (mem_req) begin
        if (cyc == 0) begin
          check({tag, " be"}, 32'(mem_be), 32'(v.be));
          check({tag, " wdata"}, mem_wd, v.mwd);
          check({tag, " addr"}, mem_addr, v.addr);
          check({tag, " we"}, 32'(mem_we), 32'(v.we));
          check({tag, " access stall"}, 32'(core_stall), 32'd1);
        end
        mem_ready = (cyc == v.waits);
        cyc++;
      end else begin
        seen_done = 1'b1;
        core_req = 1'b0;
      end
    end
    check({tag, " reached done"}, 32'(seen_done), 32'd1);
    check({tag, " access cycles"}, 32'(cyc), 32'(v.cyc));
    check({tag, " done stall"}, 32'(core_stall), 32'd0);
    check({tag, " fault"}, 32'(core_fault), 32'(v.fault));
    check({tag, " rdata"}, core_rd, v.rd);
    core_req = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check({tag, " fault pulse end"}, 32'(core_fault), 32'd0);
    check({tag, " rd held"}, core_rd, v.rd);
  endtask

  initial begin
    vec_t v, r;
    //         we    size     addr        wd            rdata         w   mis   be       mwd           rd            flt  cyc
    vecs[0]  = '{1'b0, LDST_B,  32'h103, 32'h0,        32'h80FF_0011, 0,  1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 1};
    vecs[1]  = '{1'b1, LDST_H,  32'h22,  32'h1234_ABCD, 32'h0,        0,  1'b0, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80, 1'b0, 1};
    vecs[2]  = '{1'b0, LDST_W,  32'h41,  32'h0,        32'h0,         0,  1'b1, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 0};
    vecs[3]  = '{1'b0, LDST_HU, 32'h2,   32'h0,        32'h8001_7FFF, 3,  1'b0, 4'b1100, 32'h0,        32'h0000_8001, 1'b0, 4};
    vecs[4]  = '{1'b0, LDST_H,  32'h0,   32'h0,        32'h1234_8001, 1,  1'b0, 4'b0011, 32'h0,        32'hFFFF_8001, 1'b0, 2};
    vecs[5]  = '{1'b0, LDST_BU, 32'h1,   32'h0,        32'h0000_F000, 0,  1'b0, 4'b0010, 32'h0,        32'h0000_00F0, 1'b0, 1};
    vecs[6]  = '{1'b1, LDST_B,  32'h2,   32'h0000_00A5, 32'h0,        0,  1'b0, 4'b0100, 32'hA5A5_A5A5, 32'h0000_00F0, 1'b0, 1};
    vecs[7]  = '{1'b1, LDST_W,  32'h8,   32'hDEAD_BEEF, 32'h0,        2,  1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_00F0, 1'b0, 3};
    vecs[8]  = '{1'b0, LDST_W,  32'hC,   32'h0,        32'hCAFE_F00D, 0,  1'b0, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0, 1};
    vecs[9]  = '{1'b1, LDST_BU, 32'h0,   32'h0,        32'h0,         0,  1'b1, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0, 0};
    vecs[10] = '{1'b0, LDST_H,  32'h3,   32'h0,        32'h0,         0,  1'b1, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0, 0};
    vecs[11] = '{1'b0, 3'b011,  32'h0,   32'h0,        32'h0,         0,  1'b1, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0, 0};
    vecs[12] = '{1'b0, LDST_W,  32'h20,  32'h0,        32'h5555_5555, 10, 1'b0, 4'b1111, 32'h0,        32'h0,         1'b1, 4};
    vecs[13] = '{1'b0, LDST_W,  32'h10,  32'h0,        32'h1122_3344, 3,  1'b0, 4'b1111, 32'h0,        32'h1122_3344, 1'b0, 4};
    vecs[14] = '{1'b1, LDST_W,  32'h24,  32'h0000_0055, 32'h0,        10, 1'b0, 4'b1111, 32'h0000_0055, 32'h1122_3344, 1'b1, 4};

    // Reset state, including a legal request held during reset.
    core_req = 1'b1; core_size = LDST_W; core_addr = 32'h40;
    repeat (3) @(negedge clk);
    #1;
    check("reset stall", 32'(core_stall), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset rd", core_rd, 32'd0);
    check("reset be", 32'(mem_be), 32'd0);
    check("reset addr", mem_addr, 32'd0);
    check("reset fault", 32'(core_fault), 32'd0);
    core_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
      last_rd = vecs[i].rd;
    end

    // Reset while ACCESS waits: mem_req must drop in the same cycle.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 32'h40;
    mem_rd = 32'h7777_7777; mem_ready = 1'b0;
    @(negedge clk); core_req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("rst seq mem_req before", 32'(mem_req), 32'd1);
    rst_n = 1'b0; #1;
    check("rst seq mem_req async", 32'(mem_req), 32'd0);
    check("rst seq stall async", 32'(core_stall), 32'd0);
    check("rst seq rd async", core_rd, 32'd0);
    mem_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("rst seq idle mem_req", 32'(mem_req), 32'd0);
      check("rst seq idle stall", 32'(core_stall), 32'd0);
      check("rst seq idle fault", 32'(core_fault), 32'd0);
      check("rst seq idle rd", core_rd, 32'd0);
    end
    mem_ready = 1'b0;
    last_rd = 32'd0;

    for (int i = 0; i < 200; i++) begin
      v.we    = 1'($urandom);
      v.size  = 3'($urandom);
      v.addr  = $urandom;
      v.wd    = $urandom;
      v.rdata = $urandom;
      v.waits = int'($urandom_range(0, 5));
      model(v, last_rd, r);
      run_txn(r, $sformatf("rnd%0d", i));
      last_rd = r.rd;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
